// File: rtl/img_loader.sv
// UART boot-image loader: syncs on 55 AA, parses a size header, streams words into pmem/dmem,
// verifies an 8-bit checksum and reports timeout/header/checksum errors.
module img_loader #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    PMEM_WIDTH  = 18,
  parameter int                    DMEM_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE   = 'h0100,
  parameter int                    PMEM_DEPTH  = 4096,
  parameter int                    TIMEOUT_CYC = 270000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [PMEM_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_wen,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_wen,
  output logic                  loading,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int PB   = (PMEM_WIDTH + 7) / 8;
  localparam int DB   = (DMEM_WIDTH + 7) / 8;
  localparam int MAXB = (PB > DB) ? ((PB > 4) ? PB : 4) : ((DB > 4) ? DB : 4);
  localparam int BCW  = $clog2(MAXB + 1);
  localparam int TCW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {SYNC0, SYNC1, META, PMEM, DMEM, CSUM, FIN, ERR} state_t;

  state_t                  state_reg, state_next;
  logic [BCW-1:0]          byte_cnt_reg;
  logic [TCW-1:0]          to_cnt_reg;
  logic [7:0]              sum_reg;
  logic [15:0]             pmem_size_reg, dmem_size_reg;
  logic [ADDR_WIDTH-1:0]   dmem_end_reg;
  logic [PMEM_WIDTH-1:0]   pmem_shift_reg;
  logic [DMEM_WIDTH-1:0]   dmem_shift_reg;
  logic [ADDR_WIDTH-1:0]   pmem_addr_reg, dmem_addr_reg;
  logic [PMEM_WIDTH-1:0]   pmem_wdata_reg;
  logic [DMEM_WIDTH-1:0]   dmem_wdata_reg;
  logic                    pmem_wen_reg, dmem_wen_reg, loading_reg;
  logic [1:0]              err_code_reg;

  logic                    timed_out, to_active, hdr_bad, err_set;
  logic                    pmem_word_done, dmem_word_done, pmem_last, dmem_last;
  logic [1:0]              err_cause;
  logic [7:0]              sum_next;
  logic [15:0]             dmem_size_full;
  logic [PMEM_WIDTH+7:0]   pmem_cat;
  logic [DMEM_WIDTH+7:0]   dmem_cat;
  logic [ADDR_WIDTH-1:0]   pmem_idx, dmem_idx;

  assign to_active      = (state_reg == SYNC1) || (state_reg == META) || (state_reg == PMEM) ||
                          (state_reg == DMEM)  || (state_reg == CSUM);
  assign timed_out      = !rx_valid && (to_cnt_reg == TCW'(TIMEOUT_CYC - 1));
  assign sum_next       = sum_reg + rx_byte;
  assign dmem_size_full = {dmem_size_reg[15:8], rx_byte};
  assign hdr_bad        = ({16'd0, pmem_size_reg} > 32'(PMEM_DEPTH)) ||
                          ((dmem_size_full % 16'(DB)) != 16'd0);
  assign pmem_cat       = {pmem_shift_reg, rx_byte};
  assign dmem_cat       = {dmem_shift_reg, rx_byte};
  assign pmem_word_done = rx_valid && (byte_cnt_reg == BCW'(PB - 1));
  assign dmem_word_done = rx_valid && (byte_cnt_reg == BCW'(DB - 1));
  // Effective address of the word being completed: a write still in flight bumps it by one word.
  assign pmem_idx       = pmem_addr_reg + (pmem_wen_reg ? ADDR_WIDTH'(1) : '0);
  assign dmem_idx       = dmem_addr_reg + (dmem_wen_reg ? ADDR_WIDTH'(DB) : '0);
  assign pmem_last      = (pmem_idx + ADDR_WIDTH'(1)) == ADDR_WIDTH'(pmem_size_reg);
  assign dmem_last      = (dmem_idx + ADDR_WIDTH'(DB)) == dmem_end_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= SYNC0;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    err_set    = 1'b0;
    err_cause  = 2'd0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      SYNC0: if (rx_valid && rx_byte == 8'h55) state_next = SYNC1;
      SYNC1: begin
        if (rx_valid) begin
          if (rx_byte == 8'hAA)      state_next = META;
          else if (rx_byte != 8'h55) state_next = SYNC0;
        end else if (timed_out) state_next = SYNC0;
      end
      META: begin
        if (rx_valid && byte_cnt_reg == BCW'(3)) begin
          if (hdr_bad) begin
            state_next = ERR; err_set = 1'b1; err_cause = 2'd2;
          end else if (pmem_size_reg != 16'd0) state_next = PMEM;
          else if (dmem_size_full != 16'd0)    state_next = DMEM;
          else                                 state_next = CSUM;
        end else if (timed_out) begin
          state_next = ERR; err_set = 1'b1; err_cause = 2'd1;
        end
      end
      PMEM: begin
        if (pmem_word_done && pmem_last)
          state_next = (dmem_size_reg != 16'd0) ? DMEM : CSUM;
        else if (timed_out) begin
          state_next = ERR; err_set = 1'b1; err_cause = 2'd1;
        end
      end
      DMEM: begin
        if (dmem_word_done && dmem_last) state_next = CSUM;
        else if (timed_out) begin
          state_next = ERR; err_set = 1'b1; err_cause = 2'd1;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (sum_next == 8'd0) state_next = FIN;
          else begin
            state_next = ERR; err_set = 1'b1; err_cause = 2'd3;
          end
        end else if (timed_out) begin
          state_next = ERR; err_set = 1'b1; err_cause = 2'd1;
        end
      end
      FIN: begin done = 1'b1; state_next = SYNC0; end
      ERR: begin err  = 1'b1; state_next = SYNC0; end
      default: state_next = SYNC0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_reg   <= '0;
      to_cnt_reg     <= '0;
      sum_reg        <= '0;
      pmem_size_reg  <= '0;
      dmem_size_reg  <= '0;
      dmem_end_reg   <= '0;
      pmem_shift_reg <= '0;
      dmem_shift_reg <= '0;
      pmem_addr_reg  <= '0;
      dmem_addr_reg  <= '0;
      pmem_wdata_reg <= '0;
      dmem_wdata_reg <= '0;
      pmem_wen_reg   <= 1'b0;
      dmem_wen_reg   <= 1'b0;
      loading_reg    <= 1'b0;
      err_code_reg   <= '0;
    end else begin
      pmem_wen_reg <= 1'b0;
      dmem_wen_reg <= 1'b0;
      if (pmem_wen_reg) pmem_addr_reg <= pmem_addr_reg + ADDR_WIDTH'(1);
      if (dmem_wen_reg) dmem_addr_reg <= dmem_addr_reg + ADDR_WIDTH'(DB);
      if (rx_valid || !to_active) to_cnt_reg <= '0;
      else                        to_cnt_reg <= to_cnt_reg + TCW'(1);
      case (state_reg)
        SYNC1: if (rx_valid && rx_byte == 8'hAA) begin
          loading_reg   <= 1'b1;
          err_code_reg  <= 2'd0;
          sum_reg       <= 8'd0;
          byte_cnt_reg  <= '0;
          pmem_addr_reg <= '0;
          dmem_addr_reg <= DMEM_BASE;
        end
        META: if (rx_valid) begin
          sum_reg <= sum_next;
          case (byte_cnt_reg)
            BCW'(0): pmem_size_reg[15:8] <= rx_byte;
            BCW'(1): pmem_size_reg[7:0]  <= rx_byte;
            BCW'(2): dmem_size_reg[15:8] <= rx_byte;
            default: begin
              dmem_size_reg[7:0] <= rx_byte;
              dmem_end_reg       <= DMEM_BASE + ADDR_WIDTH'(dmem_size_full);
            end
          endcase
          byte_cnt_reg <= (byte_cnt_reg == BCW'(3)) ? '0 : byte_cnt_reg + BCW'(1);
        end
        PMEM: if (rx_valid) begin
          sum_reg        <= sum_next;
          pmem_shift_reg <= pmem_cat[PMEM_WIDTH-1:0];
          if (pmem_word_done) begin
            byte_cnt_reg   <= '0;
            pmem_wen_reg   <= 1'b1;
            pmem_wdata_reg <= pmem_cat[PMEM_WIDTH-1:0];
          end else byte_cnt_reg <= byte_cnt_reg + BCW'(1);
        end
        DMEM: if (rx_valid) begin
          sum_reg        <= sum_next;
          dmem_shift_reg <= dmem_cat[DMEM_WIDTH-1:0];
          if (dmem_word_done) begin
            byte_cnt_reg   <= '0;
            dmem_wen_reg   <= 1'b1;
            dmem_wdata_reg <= dmem_cat[DMEM_WIDTH-1:0];
          end else byte_cnt_reg <= byte_cnt_reg + BCW'(1);
        end
        CSUM: if (rx_valid) sum_reg <= sum_next;
        FIN:  loading_reg <= 1'b0;
        default: ;
      endcase
      if (err_set) err_code_reg <= err_cause;
    end
  end

  assign pmem_addr  = pmem_addr_reg;
  assign pmem_wdata = pmem_wdata_reg;
  assign pmem_wen   = pmem_wen_reg;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;
  assign dmem_wen   = dmem_wen_reg;
  assign loading    = loading_reg;
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_img_loader.sv
// Directed bench for img_loader: good image, bad checksum, empty image, bad header,
// mid-load timeout and reset mid-DMEM, each followed by scoreboard checks.
module tb_img_loader;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] pmem_addr, dmem_addr, dmem_wdata;
  logic [17:0] pmem_wdata;
  logic        pmem_wen, dmem_wen, loading, done, err;
  logic [1:0]  err_code;

  img_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_wen(pmem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen),
    .loading(loading), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // write scoreboard, sampled on the falling edge
  logic [31:0] pw_a[$], pw_d[$], dw_a[$], dw_d[$];
  int done_cnt = 0, err_cnt = 0, overlap_cnt = 0;

  always @(negedge clk) begin
    if (pmem_wen) begin pw_a.push_back(32'(pmem_addr)); pw_d.push_back(32'(pmem_wdata)); end
    if (dmem_wen) begin dw_a.push_back(32'(dmem_addr)); dw_d.push_back(32'(dmem_wdata)); end
    if (pmem_wen && dmem_wen) overlap_cnt++;
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic clear_sb();
    pw_a.delete(); pw_d.delete(); dw_a.delete(); dw_d.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] q[$]);
    logic [7:0] s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return 8'h00 - s;
  endfunction

  task automatic load(input logic [7:0] body[$], input logic [7:0] adj);
    send_byte(8'h55);
    send_byte(8'hAA);
    foreach (body[i]) send_byte(body[i]);
    send_byte(csum_of(body) + adj);
    idle(3);
  endtask

  task automatic check_pw(input int i, input logic [31:0] a, input logic [31:0] d);
    check("pm_addr", (i < pw_a.size()) ? pw_a[i] : 32'hDEAD_BEEF, a);
    check("pm_data", (i < pw_d.size()) ? pw_d[i] : 32'hDEAD_BEEF, d);
  endtask

  task automatic check_dw(input int i, input logic [31:0] a, input logic [31:0] d);
    check("dm_addr", (i < dw_a.size()) ? dw_a[i] : 32'hDEAD_BEEF, a);
    check("dm_data", (i < dw_d.size()) ? dw_d[i] : 32'hDEAD_BEEF, d);
  endtask

  task automatic report(input string name);
    $display("load %s: pmem_wr=%0d dmem_wr=%0d done=%0d err=%0d err_code=%0d loading=%0b",
             name, pw_a.size(), dw_a.size(), done_cnt, err_cnt, err_code, loading);
  endtask

  task automatic check_img1();
    check("img1_pw_n", pw_a.size(), 2);
    check_pw(0, 32'h0, 32'h12345);
    check_pw(1, 32'h1, 32'h2ABCD);
    check("img1_dw_n", dw_a.size(), 1);
    check_dw(0, 32'h100, 32'h1234);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img1[$];
    logic [7:0] img2[$];
    int n;
    img1 = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    img2 = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h03, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'hAB, 8'hCD};

    idle(3);
    check("rst_loading", loading, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_pwen", pmem_wen, 0);
    check("rst_dwen", dmem_wen, 0);
    check("rst_paddr", pmem_addr, 0);
    check("rst_daddr", dmem_addr, 0);
    rst = 1'b0;
    idle(2);

    // good image
    clear_sb();
    load(img1, 8'h00);
    report("good");
    check_img1();
    check("good_done", done_cnt, 1);
    check("good_err", err_cnt, 0);
    check("good_loading", loading, 0);
    check("good_code", err_code, 0);

    // checksum off by one
    clear_sb();
    load(img1, 8'h01);
    report("bad_csum");
    check("bcs_done", done_cnt, 0);
    check("bcs_err", err_cnt, 1);
    check("bcs_code", err_code, 3);
    check("bcs_loading", loading, 1);

    // 55 55 AA and an empty image
    clear_sb();
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    idle(3);
    report("empty");
    check("empty_pw_n", pw_a.size(), 0);
    check("empty_dw_n", dw_a.size(), 0);
    check("empty_done", done_cnt, 1);
    check("empty_loading", loading, 0);

    // dmem_size not a multiple of the word size
    clear_sb();
    send_byte(8'h55); send_byte(8'hAA);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h03);
    check("hdr_err_imm", err, 1);
    check("hdr_code", err_code, 2);
    idle(3);
    report("bad_hdr");
    check("hdr_err_n", err_cnt, 1);
    check("hdr_writes", pw_a.size() + dw_a.size(), 0);
    check("hdr_loading", loading, 1);

    // stall mid-PMEM until the timeout fires
    clear_sb();
    send_byte(8'h55); send_byte(8'hAA);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23);
    n = 0;
    while (!err && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, TO);
    check("to_code", err_code, 1);
    check("to_loading", loading, 1);
    idle(2);
    report("timeout");
    check("to_pw_n", pw_a.size(), 0);

    clear_sb();
    load(img1, 8'h00);
    report("after_timeout");
    check_img1();
    check("reload_done", done_cnt, 1);
    check("reload_code", err_code, 0);
    check("reload_loading", loading, 0);

    // reset mid-DMEM
    clear_sb();
    send_byte(8'h55); send_byte(8'hAA);
    for (int i = 0; i < 10; i++) send_byte(img2[i]);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_loading", loading, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_code", err_code, 0);
    check("mrst_pwen", pmem_wen, 0);
    check("mrst_dwen", dmem_wen, 0);
    check("mrst_paddr", pmem_addr, 0);
    check("mrst_daddr", dmem_addr, 0);
    check("mrst_pdata", pmem_wdata, 0);
    check("mrst_ddata", dmem_wdata, 0);
    rst = 1'b0;
    n = dw_a.size();
    idle(TO + 5);
    report("reset_mid_dmem");
    check("mrst_no_wr", dw_a.size(), n);
    check("mrst_no_err", err_cnt, 0);

    clear_sb();
    load(img2, 8'h00);
    report("replay");
    check("rep_pw_n", pw_a.size(), 1);
    check_pw(0, 32'h0, 32'h3FFFF);
    check("rep_dw_n", dw_a.size(), 2);
    check_dw(0, 32'h100, 32'h1234);
    check_dw(1, 32'h102, 32'hABCD);
    check("rep_done", done_cnt, 1);
    check("rep_loading", loading, 0);
    check("overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
